sdram_rd_checker: RTL and testbench
===================================

// Module: sdram_rd_checker
// PURPOSE
//  Downstream consumer of the SDRAM read/write test sequencer. Snoops its write stream into a shadow table.
//  Matches in-order SDRAM read returns against the expected words and counts mismatches.
//  Shows the last returned word on a 7-segment digit and reports PASS/FAIL.
//  Sits between the SDRAM controller's Avalon-style read-return port and the board LEDs/HEX.
// PARAMETERS
//  ADDR_W     25  address width, same as the sequencer
//  DATA_W     16  data width
//  TBL_AW      4  shadow-table index bits; the table has 2**TBL_AW entries indexed by addr[TBL_AW-1:0]
//  RDQ_AW      3  pending-read FIFO address bits; the FIFO has 2**RDQ_AW entries
//  EXP_READS   9  number of read returns after which the run is judged
// PORTS
//  iCLK            in   1       system clock
//  iRST_n          in   1       asynchronous active-low reset
//  iWRITE          in   1       write request from the sequencer
//  iWRITEDATA      in   DATA_W  write data
//  iWR_ADDR        in   ADDR_W  write address
//  iREAD           in   1       read request from the sequencer
//  iRD_ADDR        in   ADDR_W  read address
//  iWAITREQUEST    in   1       controller stall; a request is accepted only when this is 0
//  iREADDATA       in   DATA_W  read return data
//  iREADDATAVALID  in   1       qualifies iREADDATA; returns arrive in issue order
//  oHEX0           out  7       active-low segments showing the last returned word
//  oRD_CNT         out  8       number of returns consumed, saturating at 255
//  oERR_CNT        out  8       number of mismatches, saturating at 255
//  oPROTO_ERR      out  1       sticky flag: FIFO overflow or unexpected return
//  oPASS           out  1       run finished with no errors
//  oFAIL           out  1       run finished with at least one error
// BEHAVIOUR
//  - Reset (async, any time, including mid-run):
//    - table valid bits = 0, FIFO empty, state = IDLE
//    - oHEX0 = 7'h7F (blank), oRD_CNT = oERR_CNT = 0, oPROTO_ERR = oPASS = oFAIL = 0
//  - Write accept (wr_acc) = iWRITE & ~iWAITREQUEST:
//    - tbl[iWR_ADDR[TBL_AW-1:0]] <= iWRITEDATA and the entry's valid bit is set, both on the next edge.
//  - Read accept (rd_acc) = iREAD & ~iWAITREQUEST:
//    - iRD_ADDR[TBL_AW-1:0] is pushed into the FIFO.
//    - If the FIFO is full with no pop in the same cycle, the push is dropped and oPROTO_ERR is set.
//    - A push and a pop in the same cycle while the FIFO is full is legal; the count is unchanged.
//  - Return (iREADDATAVALID = 1):
//    - If the FIFO is empty, the return is ignored and oPROTO_ERR is set.
//    - Otherwise the FIFO head is popped and its index idx is used for the compare.
//    - Compare registers 1 cycle after the return:
//      - oRD_CNT increments.
//      - oERR_CNT increments if ~valid[idx] or iREADDATA != tbl[idx].
//      - oHEX0 is updated.
//  - Write to idx in the same cycle as a return for idx: the compare uses the old table contents.
//  - Counters saturate at 8'hFF and never wrap.
//  - FSM:
//    - IDLE: waits for the first wr_acc or rd_acc, then goes to RUN.
//    - RUN: when the oRD_CNT update reaches EXP_READS, goes to DONE in the same cycle as that update.
//    - DONE: oPASS = (oERR_CNT == 0 & ~oPROTO_ERR); oFAIL = ~oPASS. Both are registered and held.
//      Further traffic is still snooped, but the counters, verdict and oHEX0 are frozen.
//    - DONE is left only by reset.
//  - oPASS and oFAIL are 0 outside DONE.
// CONFIGURATION
//  RDCHK_HEX_DECODE_EN
//   - Defined: oHEX0 = active-low hex-digit decode of iREADDATA[3:0] (0-F glyphs).
//   - Undefined: oHEX0 = iREADDATA[6:0] raw, because the sequencer writes segment codes.
//   - Either way oHEX0 is registered and keeps the same 1-cycle latency.
// TESTING
//  1. Write idx1-10 with segment codes for 0-9, then read idx1-9 in order, with returns 3 cycles after
//     each read. Required: oRD_CNT = 9, oERR_CNT = 0, oPASS = 1, oHEX0 = 7'b0010000 after the last return.
//  2. As test 1, but return 16'h0000 for idx5. Required: oERR_CNT = 1, oFAIL = 1, oPASS = 0.
//  3. Read idx12, which was never written, and return any data. Required: oERR_CNT increments.
//  4. Hold iWAITREQUEST = 1 while iREAD/iWRITE are asserted. Required: no FIFO push, no table
//     update, oRD_CNT unchanged.
//  5. Issue 9 reads with no returns. Required: oPROTO_ERR = 1 on the 9th read.
//     Separately, assert iREADDATAVALID with the FIFO empty. Required: oPROTO_ERR = 1, oRD_CNT unchanged.
//  6. Assert iRST_n low mid-run, between clock edges. Required: all outputs return to reset values
//     immediately; with RDCHK_HEX_DECODE_EN defined and a return of 16'h0003, oHEX0 = 7'b0110000.

Source files
------------

// File: rtl/sdram_rd_checker_if.sv
// Bus bundle between the SDRAM test sequencer/controller and the read checker.
// The checker takes the slave side; the driving environment takes the master side.
interface sdram_rd_checker_if #(
  parameter int ADDR_W = 25,
  parameter int DATA_W = 16
);
  logic              iWRITE;
  logic [DATA_W-1:0] iWRITEDATA;
  logic [ADDR_W-1:0] iWR_ADDR;
  logic              iREAD;
  logic [ADDR_W-1:0] iRD_ADDR;
  logic              iWAITREQUEST;
  logic [DATA_W-1:0] iREADDATA;
  logic              iREADDATAVALID;
  logic [6:0]        oHEX0;
  logic [7:0]        oRD_CNT;
  logic [7:0]        oERR_CNT;
  logic              oPROTO_ERR;
  logic              oPASS;
  logic              oFAIL;

  modport slave (
    input  iWRITE, iWRITEDATA, iWR_ADDR, iREAD, iRD_ADDR,
           iWAITREQUEST, iREADDATA, iREADDATAVALID,
    output oHEX0, oRD_CNT, oERR_CNT, oPROTO_ERR, oPASS, oFAIL
  );

  modport master (
    output iWRITE, iWRITEDATA, iWR_ADDR, iREAD, iRD_ADDR,
           iWAITREQUEST, iREADDATA, iREADDATAVALID,
    input  oHEX0, oRD_CNT, oERR_CNT, oPROTO_ERR, oPASS, oFAIL
  );
endinterface

// File: rtl/sdram_rd_checker.sv
// SDRAM read-return checker: shadows sequencer writes, matches in-order returns, reports PASS/FAIL.
// Optional macro RDCHK_HEX_DECODE_EN: oHEX0 shows a hex-digit glyph of iREADDATA[3:0] instead of raw segments.
module sdram_rd_checker #(
  parameter int ADDR_W    = 25,
  parameter int DATA_W    = 16,
  parameter int TBL_AW    = 4,
  parameter int RDQ_AW    = 3,
  parameter int EXP_READS = 9
) (
  input logic                iCLK,
  input logic                iRST_n,
  sdram_rd_checker_if.slave  bus
);
  localparam int TBL_N = 1 << TBL_AW;
  localparam int RDQ_N = 1 << RDQ_AW;
  localparam logic [RDQ_AW:0] RDQ_FULL = (RDQ_AW + 1)'(RDQ_N);
  localparam logic [7:0]      EXP_CNT  = 8'(EXP_READS);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2
  } state_t;

`ifdef RDCHK_HEX_DECODE_EN
  function automatic logic [6:0] hex_to_seg(input logic [3:0] nib);
    logic [6:0] seg;
    case (nib)
      4'h0: seg = 7'b1000000;
      4'h1: seg = 7'b1111001;
      4'h2: seg = 7'b0100100;
      4'h3: seg = 7'b0110000;
      4'h4: seg = 7'b0011001;
      4'h5: seg = 7'b0010010;
      4'h6: seg = 7'b0000010;
      4'h7: seg = 7'b1111000;
      4'h8: seg = 7'b0000000;
      4'h9: seg = 7'b0010000;
      4'hA: seg = 7'b0001000;
      4'hB: seg = 7'b0000011;
      4'hC: seg = 7'b1000110;
      4'hD: seg = 7'b0100001;
      4'hE: seg = 7'b0000110;
      4'hF: seg = 7'b0001110;
      default: seg = 7'b1111111;
    endcase
    return seg;
  endfunction
`endif

  logic [DATA_W-1:0] tbl_q [TBL_N];
  logic [DATA_W-1:0] tbl_d [TBL_N];
  logic [TBL_N-1:0]  vld_q, vld_d;
  logic [TBL_AW-1:0] rdq_q [RDQ_N];
  logic [TBL_AW-1:0] rdq_d [RDQ_N];
  logic [RDQ_AW-1:0] wptr_q, wptr_d, rptr_q, rptr_d;
  logic [RDQ_AW:0]   cnt_q, cnt_d;
  state_t            state_q, state_d;
  logic [7:0]        rd_cnt_q, rd_cnt_d, err_cnt_q, err_cnt_d;
  logic [6:0]        hex_q, hex_d;
  logic              proto_q, proto_d, pass_q, pass_d, fail_q, fail_d;

  logic              wr_acc_s, rd_acc_s, empty_s, full_s;
  logic              push_s, pop_s, ovf_s, unexp_s, cmp_en_s, mismatch_s;
  logic [TBL_AW-1:0] wr_idx_s, rd_idx_s, head_idx_s;
  logic [6:0]        seg_s;
  logic              unused_addr_s;

  assign wr_acc_s   = bus.iWRITE & ~bus.iWAITREQUEST;
  assign rd_acc_s   = bus.iREAD  & ~bus.iWAITREQUEST;
  assign wr_idx_s   = bus.iWR_ADDR[TBL_AW-1:0];
  assign rd_idx_s   = bus.iRD_ADDR[TBL_AW-1:0];
  assign empty_s    = (cnt_q == '0);
  assign full_s     = (cnt_q == RDQ_FULL);
  assign pop_s      = bus.iREADDATAVALID & ~empty_s;
  assign unexp_s    = bus.iREADDATAVALID & empty_s;
  // A full FIFO still accepts a push when the head leaves in the same cycle.
  assign push_s     = rd_acc_s & (~full_s | pop_s);
  assign ovf_s      = rd_acc_s & full_s & ~pop_s;
  assign head_idx_s = rdq_q[rptr_q];
  assign cmp_en_s   = pop_s & (state_q != ST_DONE);
  assign mismatch_s = ~vld_q[head_idx_s] | (bus.iREADDATA != tbl_q[head_idx_s]);
  assign unused_addr_s = ^{bus.iWR_ADDR[ADDR_W-1:TBL_AW], bus.iRD_ADDR[ADDR_W-1:TBL_AW]};

`ifdef RDCHK_HEX_DECODE_EN
  assign seg_s = hex_to_seg(bus.iREADDATA[3:0]);
`else
  assign seg_s = bus.iREADDATA[6:0];
`endif

  // Shadow table snoops every accepted write, in every state.
  always_comb begin
    tbl_d = tbl_q;
    vld_d = vld_q;
    if (wr_acc_s) begin
      tbl_d[wr_idx_s] = bus.iWRITEDATA;
      vld_d[wr_idx_s] = 1'b1;
    end else begin
      vld_d = vld_q;
    end
  end

  // Pending-read FIFO pointers and occupancy.
  always_comb begin
    rdq_d  = rdq_q;
    wptr_d = wptr_q;
    rptr_d = rptr_q;
    if (push_s) begin
      rdq_d[wptr_q] = rd_idx_s;
      wptr_d        = wptr_q + 1'b1;
    end else begin
      wptr_d = wptr_q;
    end
    if (pop_s) begin
      rptr_d = rptr_q + 1'b1;
    end else begin
      rptr_d = rptr_q;
    end
    case ({push_s, pop_s})
      2'b10:   cnt_d = cnt_q + 1'b1;
      2'b01:   cnt_d = cnt_q - 1'b1;
      default: cnt_d = cnt_q;
    endcase
  end

  // Compare results, counters and display; frozen once the run is judged.
  always_comb begin
    rd_cnt_d  = rd_cnt_q;
    err_cnt_d = err_cnt_q;
    hex_d     = hex_q;
    proto_d   = proto_q | ovf_s | unexp_s;
    if (cmp_en_s) begin
      hex_d = seg_s;
      if (rd_cnt_q != 8'hFF) begin
        rd_cnt_d = rd_cnt_q + 8'd1;
      end else begin
        rd_cnt_d = rd_cnt_q;
      end
      if (mismatch_s && (err_cnt_q != 8'hFF)) begin
        err_cnt_d = err_cnt_q + 8'd1;
      end else begin
        err_cnt_d = err_cnt_q;
      end
    end else begin
      hex_d = hex_q;
    end
  end

  // FSM next state.
  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE: begin
        if (wr_acc_s || rd_acc_s) begin
          state_d = ST_RUN;
        end else begin
          state_d = ST_IDLE;
        end
      end
      ST_RUN: begin
        if (cmp_en_s && (rd_cnt_d == EXP_CNT)) begin
          state_d = ST_DONE;
        end else begin
          state_d = ST_RUN;
        end
      end
      ST_DONE: state_d = ST_DONE;
      default: state_d = ST_IDLE;
    endcase
  end

  // FSM outputs: verdict is captured on entry to DONE and held until reset.
  always_comb begin
    pass_d = pass_q;
    fail_d = fail_q;
    if ((state_q != ST_DONE) && (state_d == ST_DONE)) begin
      pass_d = (err_cnt_d == 8'd0) & ~proto_d;
      fail_d = ~((err_cnt_d == 8'd0) & ~proto_d);
    end else begin
      pass_d = pass_q;
      fail_d = fail_q;
    end
  end

  // State register.
  always_ff @(posedge iCLK or negedge iRST_n) begin
    if (!iRST_n) begin
      tbl_q     <= '{default: '0};
      vld_q     <= '0;
      rdq_q     <= '{default: '0};
      wptr_q    <= '0;
      rptr_q    <= '0;
      cnt_q     <= '0;
      state_q   <= ST_IDLE;
      rd_cnt_q  <= 8'd0;
      err_cnt_q <= 8'd0;
      hex_q     <= 7'h7F;
      proto_q   <= 1'b0;
      pass_q    <= 1'b0;
      fail_q    <= 1'b0;
    end else begin
      tbl_q     <= tbl_d;
      vld_q     <= vld_d;
      rdq_q     <= rdq_d;
      wptr_q    <= wptr_d;
      rptr_q    <= rptr_d;
      cnt_q     <= cnt_d;
      state_q   <= state_d;
      rd_cnt_q  <= rd_cnt_d;
      err_cnt_q <= err_cnt_d;
      hex_q     <= hex_d;
      proto_q   <= proto_d;
      pass_q    <= pass_d;
      fail_q    <= fail_d;
    end
  end

  assign bus.oHEX0      = hex_q;
  assign bus.oRD_CNT    = rd_cnt_q;
  assign bus.oERR_CNT   = err_cnt_q;
  assign bus.oPROTO_ERR = proto_q;
  assign bus.oPASS      = pass_q;
  assign bus.oFAIL      = fail_q;
endmodule

// File: tb/tb_sdram_rd_checker.sv
// Scoreboard bench for sdram_rd_checker: a queue-based reference model predicts outputs per return.
module tb_sdram_rd_checker;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  sdram_rd_checker_if #(.ADDR_W(25), .DATA_W(16)) bus ();

  sdram_rd_checker #(
    .ADDR_W(25), .DATA_W(16), .TBL_AW(4), .RDQ_AW(3), .EXP_READS(9)
  ) dut (
    .iCLK  (clk),
    .iRST_n(rst_n),
    .bus   (bus)
  );

  int total = 0;
  int bad   = 0;

  // Reference model state
  logic [15:0] m_tbl [16];
  bit          m_vld [16];
  int          m_pend [$];
  int          m_rd, m_err;
  logic [6:0]  m_hex;
  bit          m_proto, m_pass, m_fail, m_done;

  typedef struct {
    int rd; int err; logic [6:0] hex; bit proto; bit pass; bit fail;
  } snap_t;
  snap_t exp_q [$];

  logic [6:0] seg7 [10] = '{7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78, 7'h00, 7'h10};
  logic [6:0] hexg [16] = '{7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78,
                            7'h00, 7'h10, 7'h08, 7'h03, 7'h46, 7'h21, 7'h06, 7'h0E};

  function automatic logic [6:0] show(logic [15:0] d);
`ifdef RDCHK_HEX_DECODE_EN
    return hexg[d[3:0]];
`else
    return d[6:0];
`endif
  endfunction

  task automatic chk(string nm, logic [31:0] act, logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    for (int i = 0; i < 16; i++) begin m_tbl[i] = 16'h0; m_vld[i] = 1'b0; end
    m_pend.delete();
    exp_q.delete();
    m_rd = 0; m_err = 0; m_hex = 7'h7F;
    m_proto = 1'b0; m_pass = 1'b0; m_fail = 1'b0; m_done = 1'b0;
  endtask

  // One clock cycle of bus activity applied to the model.
  task automatic step(bit w, logic [15:0] wd, int wa, bit r, int ra, bit wt, bit rv, logic [15:0] rdat);
    bit judged = 1'b0;
    int idx;
    if (rv) begin
      if (m_pend.size() == 0) m_proto = 1'b1;
      else begin
        idx = m_pend.pop_front();
        if (!m_done) begin
          if (m_rd < 255) m_rd++;
          if ((!m_vld[idx] || rdat != m_tbl[idx]) && m_err < 255) m_err++;
          m_hex = show(rdat);
          if (m_rd == 9) judged = 1'b1;
        end
      end
    end
    if (r && !wt) begin
      if (m_pend.size() >= 8) m_proto = 1'b1;
      else m_pend.push_back(ra % 16);
    end
    if (w && !wt) begin m_tbl[wa % 16] = wd; m_vld[wa % 16] = 1'b1; end
    if (judged) begin
      m_done = 1'b1;
      m_pass = (m_err == 0) && !m_proto;
      m_fail = !m_pass;
    end
    if (rv) exp_q.push_back('{m_rd, m_err, m_hex, m_proto, m_pass, m_fail});
  endtask

  task automatic drive(bit w, logic [15:0] wd, int wa, bit r, int ra, bit wt, bit rv, logic [15:0] rdat);
    @(negedge clk);
    bus.iWRITE = w; bus.iWRITEDATA = wd; bus.iWR_ADDR = 25'(wa);
    bus.iREAD = r;  bus.iRD_ADDR = 25'(ra + 32'h100);
    bus.iWAITREQUEST = wt; bus.iREADDATAVALID = rv; bus.iREADDATA = rdat;
    step(w, wd, wa, r, ra, wt, rv, rdat);
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    drive(1'b0, 16'h0, 0, 1'b0, 0, 1'b0, 1'b0, 16'h0);
  endtask

  task automatic chk_model(string nm);
    chk({nm, ".rd"},    32'(bus.oRD_CNT),    32'(m_rd));
    chk({nm, ".err"},   32'(bus.oERR_CNT),   32'(m_err));
    chk({nm, ".hex"},   32'(bus.oHEX0),      32'(m_hex));
    chk({nm, ".proto"}, 32'(bus.oPROTO_ERR), 32'(m_proto));
    chk({nm, ".pass"},  32'(bus.oPASS),      32'(m_pass));
    chk({nm, ".fail"},  32'(bus.oFAIL),      32'(m_fail));
  endtask

  task automatic chk_reset_vals(string nm);
    chk({nm, ".hex"},   32'(bus.oHEX0),      32'h7F);
    chk({nm, ".rd"},    32'(bus.oRD_CNT),    32'h0);
    chk({nm, ".err"},   32'(bus.oERR_CNT),   32'h0);
    chk({nm, ".proto"}, 32'(bus.oPROTO_ERR), 32'h0);
    chk({nm, ".pass"},  32'(bus.oPASS),      32'h0);
    chk({nm, ".fail"},  32'(bus.oFAIL),      32'h0);
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst_n = 1'b0;
    bus.iWRITE = 1'b0; bus.iREAD = 1'b0; bus.iREADDATAVALID = 1'b0; bus.iWAITREQUEST = 1'b0;
    bus.iWRITEDATA = 16'h0; bus.iWR_ADDR = 25'h0; bus.iRD_ADDR = 25'h0; bus.iREADDATA = 16'h0;
    model_reset();
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  // Writes idx1-10 with digit codes (idx k holds digit k mod 10), then reads idx1-9.
  task automatic seq_test(int bad_idx);
    for (int k = 1; k <= 10; k++) drive(1'b1, {9'h0, seg7[k % 10]}, k, 1'b0, 0, 1'b0, 1'b0, 16'h0);
    for (int k = 1; k <= 9; k++) begin
      drive(1'b0, 16'h0, 0, 1'b1, k, 1'b0, 1'b0, 16'h0);
      idle();
      idle();
      drive(1'b0, 16'h0, 0, 1'b0, 0, 1'b0, 1'b1, (k == bad_idx) ? 16'h0 : {9'h0, seg7[k % 10]});
    end
    idle();
  endtask

  // Scoreboard monitor: every return the DUT sees is checked one cycle later.
  initial begin
    snap_t s;
    bit v;
    forever begin
      @(posedge clk);
      v = bus.iREADDATAVALID && rst_n;
      #1;
      if (v) begin
        if (exp_q.size() == 0) begin
          total++; bad++;
          $display("FAIL sb_underflow: got return with no expectation at %0t", $time);
        end else begin
          s = exp_q.pop_front();
          chk("sb.rd",    32'(bus.oRD_CNT),    32'(s.rd));
          chk("sb.err",   32'(bus.oERR_CNT),   32'(s.err));
          chk("sb.hex",   32'(bus.oHEX0),      32'(s.hex));
          chk("sb.proto", 32'(bus.oPROTO_ERR), 32'(s.proto));
          chk("sb.pass",  32'(bus.oPASS),      32'(s.pass));
          chk("sb.fail",  32'(bus.oFAIL),      32'(s.fail));
        end
      end
    end
  end

  initial begin
    #3000000;
    bad++;
    $display("FAIL watchdog: got timeout expected finish");
    $display("test done: total=%0d bad=%0d", total, bad);
    $fatal(1, "watchdog");
  end

  initial begin
    int head;
    bit w, r, wt, rv;
    logic [15:0] d;
    do_reset();
    #1;
    chk_reset_vals("reset");

    // Clean sequential run
    seq_test(0);
    chk("t1.rd", 32'(bus.oRD_CNT), 32'd9);
    chk("t1.err", 32'(bus.oERR_CNT), 32'd0);
    chk("t1.pass", 32'(bus.oPASS), 32'd1);
`ifndef RDCHK_HEX_DECODE_EN
    chk("t1.hex", 32'(bus.oHEX0), 32'h10);
`endif
    // Traffic after DONE is frozen
    drive(1'b0, 16'h0, 0, 1'b1, 2, 1'b0, 1'b0, 16'h0);
    drive(1'b0, 16'h0, 0, 1'b0, 0, 1'b0, 1'b1, 16'hBEEF);
    chk_model("t1.frozen");

    // One bad word
    do_reset();
    seq_test(5);
    chk("t2.err", 32'(bus.oERR_CNT), 32'd1);
    chk("t2.fail", 32'(bus.oFAIL), 32'd1);
    chk("t2.pass", 32'(bus.oPASS), 32'd0);

    // Unwritten entry, then stalled requests
    do_reset();
    drive(1'b1, 16'h0011, 1, 1'b0, 0, 1'b0, 1'b0, 16'h0);
    drive(1'b0, 16'h0, 0, 1'b1, 12, 1'b0, 1'b0, 16'h0);
    drive(1'b0, 16'h0, 0, 1'b0, 0, 1'b0, 1'b1, 16'h1234);
    chk("t3.err", 32'(bus.oERR_CNT), 32'd1);
    drive(1'b1, 16'h00AA, 3, 1'b1, 3, 1'b1, 1'b0, 16'h0);
    chk("t4.rd", 32'(bus.oRD_CNT), 32'd1);
    drive(1'b0, 16'h0, 0, 1'b0, 0, 1'b0, 1'b1, 16'h00AA);
    chk("t4.nopush.proto", 32'(bus.oPROTO_ERR), 32'd1);
    chk("t4.nopush.rd", 32'(bus.oRD_CNT), 32'd1);
    drive(1'b0, 16'h0, 0, 1'b1, 3, 1'b0, 1'b0, 16'h0);
    drive(1'b0, 16'h0, 0, 1'b0, 0, 1'b0, 1'b1, 16'h00AA);
    chk("t4.notbl.err", 32'(bus.oERR_CNT), 32'd2);

    // FIFO overflow on the 9th outstanding read
    do_reset();
    for (int k = 0; k < 8; k++) drive(1'b0, 16'h0, 0, 1'b1, k, 1'b0, 1'b0, 16'h0);
    chk("t5.proto8", 32'(bus.oPROTO_ERR), 32'd0);
    drive(1'b0, 16'h0, 0, 1'b1, 8, 1'b0, 1'b0, 16'h0);
    chk("t5.proto9", 32'(bus.oPROTO_ERR), 32'd1);
    // Full FIFO with simultaneous pop and push is legal
    do_reset();
    for (int k = 0; k < 8; k++) drive(1'b1, 16'(k), k, 1'b1, k, 1'b0, 1'b0, 16'h0);
    drive(1'b0, 16'h0, 0, 1'b1, 2, 1'b0, 1'b1, 16'h0);
    chk_model("t5.pushpop");
    // Unexpected return
    do_reset();
    drive(1'b0, 16'h0, 0, 1'b0, 0, 1'b0, 1'b1, 16'h5555);
    chk("t5.unexp.proto", 32'(bus.oPROTO_ERR), 32'd1);
    chk("t5.unexp.rd", 32'(bus.oRD_CNT), 32'd0);

    // Randomized traffic against the model
    for (int round = 0; round < 8; round++) begin
      do_reset();
      for (int c = 0; c < 120; c++) begin
        w  = ($urandom % 3) == 0;
        r  = ($urandom % 3) == 0;
        wt = ($urandom % 5) == 0;
        rv = (m_pend.size() != 0) ? ($urandom % 2 == 0) : ($urandom % 40 == 0);
        head = (m_pend.size() != 0) ? m_pend[0] : 0;
        d = (($urandom % 4) == 0 || !rv) ? 16'($urandom) : m_tbl[head];
        drive(w, 16'($urandom % 128), $urandom % 6, r, $urandom % 7, wt, rv, d);
      end
      chk_model("rand.end");
    end

    // Asynchronous reset between edges mid-run
    do_reset();
    drive(1'b1, 16'h0003, 0, 1'b0, 0, 1'b0, 1'b0, 16'h0);
    drive(1'b0, 16'h0, 0, 1'b1, 0, 1'b0, 1'b0, 16'h0);
    drive(1'b0, 16'h0, 0, 1'b0, 0, 1'b0, 1'b1, 16'h0003);
`ifdef RDCHK_HEX_DECODE_EN
    chk("t6.hex", 32'(bus.oHEX0), 32'h30);
`else
    chk("t6.hex", 32'(bus.oHEX0), 32'h03);
`endif
    drive(1'b0, 16'h0, 0, 1'b1, 0, 1'b0, 1'b0, 16'h0);
    drive(1'b0, 16'h0, 0, 1'b0, 0, 1'b0, 1'b0, 16'h0);
    #2;
    rst_n = 1'b0;
    #1;
    chk_reset_vals("t6.async");
    model_reset();
    bus.iREAD = 1'b0; bus.iWRITE = 1'b0; bus.iREADDATAVALID = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    drive(1'b0, 16'h0, 0, 1'b0, 0, 1'b0, 1'b1, 16'h0);
    chk("t6.fifo_cleared", 32'(bus.oPROTO_ERR), 32'd1);
    idle();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
